mix_column_engine: RTL and testbench

//  Iterative AES MixColumns / InvMixColumns engine with a valid/ready handshake on both sides.

---
 rtl/mix_column_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_mix_column_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_engine.sv
// ---------------------------------------------------------------------------
// mix_column_engine
//
// Iterative AES MixColumns / InvMixColumns engine. One 128-bit state block is
// accepted, its four columns are transformed COLS_PER_CYCLE at a time, and the
// result is held until downstream takes it. The same engine serves both the
// encryption and the decryption round datapaths; the direction is chosen per
// block.
//
// Parameters
//   COLS_PER_CYCLE : columns processed per BUSY cycle (1, 2 or 4).
//                    Latency from accept to out_valid is 4/COLS_PER_CYCLE.
//
// Configuration macro
//   MIXCOL_PARITY_EN : when defined, adds out_parity (even parity per byte of
//                      out_data, registered alongside it).
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   flush      in   1    synchronous abort, drops the block in flight
//   in_valid   in   1    in_data / in_inv valid
//   in_ready   out  1    engine can accept a block (IDLE only)
//   in_data    in   128  state; column c = [127-32c -: 32], row 0 is MSB byte
//   in_inv     in   1    0 = MixColumns, 1 = InvMixColumns
//   out_valid  out  1    out_data valid
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  result, same layout as in_data
//   out_parity out  16   (MIXCOL_PARITY_EN only) bit i = ^out_data[8i+7:8i]
//   busy       out  1    high in BUSY or DONE
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload until that edge; ready may
// change freely. Here in_ready depends only on FSM state and out_valid is a
// flop, so neither side has a combinational path from the other.
// ---------------------------------------------------------------------------
module mix_column_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef MIXCOL_PARITY_EN
    output logic [15:0]  out_parity,
`endif
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // For COLS_PER_CYCLE=4 the step truncates to 0: the counter stays at 0
    // and the single BUSY cycle is also the last one.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    // ------------------------------------------------------------------
    // GF(2^8) helpers, polynomial 0x11b
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Transform one 32-bit column. Row r of the result is
    //   m0[r] ^ m1[r+1] ^ m2[r+2] ^ m3[r+3]  (indices mod 4)
    // where m0..m3 are the input bytes multiplied by the four coefficients of
    // the selected row-0 vector; that is exactly the circulant matrix product.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  m0 [4];
        logic [7:0]  m1 [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m3 [4];
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            if (inv) begin
                m0[i] = x8[i] ^ x4[i] ^ x2[i];   // 0e
                m1[i] = x8[i] ^ x2[i] ^ a[i];    // 0b
                m2[i] = x8[i] ^ x4[i] ^ a[i];    // 0d
                m3[i] = x8[i] ^ a[i];            // 09
            end else begin
                m0[i] = x2[i];                   // 02
                m1[i] = x2[i] ^ a[i];            // 03
                m2[i] = a[i];                    // 01
                m3[i] = a[i];                    // 01
            end
        end
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = m0[r] ^ m1[(r+1)%4] ^ m2[(r+2)%4] ^ m3[(r+3)%4];
        end
        return res;
    endfunction

`ifdef MIXCOL_PARITY_EN
    function automatic logic [15:0] byte_parity(input logic [127:0] d);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]   state_q,     state_d;
    logic [1:0]   col_cnt_q,   col_cnt_d;
    logic [127:0] data_q,      data_d;
    logic         inv_q,       inv_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q,  out_data_d;
`ifdef MIXCOL_PARITY_EN
    logic [15:0]  out_parity_q, out_parity_d;
`endif

    logic [1:0]   col_idx;
    logic [6:0]   col_msb;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef MIXCOL_PARITY_EN
    assign out_parity = out_parity_q;
`endif

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        data_d      = data_q;
        inv_d       = inv_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        col_idx     = '0;
        col_msb     = '0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    data_d    = in_data;
                    inv_d     = in_inv;
                    col_cnt_d = '0;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Columns are written into out_data in place; the columns not
                // yet reached keep whatever the previous block left there.
                for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                    col_idx = col_cnt_q + 2'(j);
                    col_msb = 7'd127 - {col_idx, 5'd0};
                    out_data_d[col_msb -: 32] = mix_col(data_q[col_msb -: 32], inv_q);
                end
                col_cnt_d = col_cnt_q + COL_STEP;
                if (col_cnt_q == LAST_COL) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end

            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort overrides everything above: no accept, no transfer, and
        // out_data keeps its current contents.
        if (flush) begin
            state_d     = ST_IDLE;
            col_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            data_d      = data_q;
            inv_d       = inv_q;
        end
    end

`ifdef MIXCOL_PARITY_EN
    always_comb begin
        out_parity_d = byte_parity(out_data_d);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_cnt_q    <= '0;
            data_q       <= '0;
            inv_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
`ifdef MIXCOL_PARITY_EN
            out_parity_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            data_q       <= data_d;
            inv_q        <= inv_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
`ifdef MIXCOL_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_mix_column_engine.sv
// ---------------------------------------------------------------------------
// tb_mix_column_engine
//
// Three engines (COLS_PER_CYCLE = 1, 2, 4) share clock and reset. Directed
// vectors cover reset values, forward/inverse results, latency, backpressure,
// flush, asynchronous reset mid-block, then random forward/inverse round trips
// checked against a matrix-product reference model.
// ---------------------------------------------------------------------------
module tb_mix_column_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush     [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_inv    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];
`ifdef MIXCOL_PARITY_EN
    logic [15:0]  out_parity[3];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int C = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
            mix_column_engine #(.COLS_PER_CYCLE(C)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush[g]),
                .in_valid   (in_valid[g]),
                .in_ready   (in_ready[g]),
                .in_data    (in_data[g]),
                .in_inv     (in_inv[g]),
                .out_valid  (out_valid[g]),
                .out_ready  (out_ready[g]),
                .out_data   (out_data[g]),
`ifdef MIXCOL_PARITY_EN
                .out_parity (out_parity[g]),
`endif
                .busy       (busy[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reference model: generic shift-and-add GF multiply, matrix product
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [7:0]   v [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) begin
            v[0] = 8'h0e; v[1] = 8'h0b; v[2] = 8'h0d; v[3] = 8'h09;
        end else begin
            v[0] = 8'h02; v[1] = 8'h03; v[2] = 8'h01; v[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(v[(k - r + 4) % 4], d[127 - 32*c - 8*k -: 8]);
                end
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] exp_parity(input logic [127:0] d);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks (all called at the #1-after-rising-edge phase)
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and return just after the accepting edge. The inputs are
    // then scrambled so that a design which does not latch them shows it.
    task automatic send(input int k, input logic [127:0] d, input logic inv);
        int n;
        n = 0;
        in_data[k]  = d;
        in_inv[k]   = inv;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 20) begin
            tick();
            n++;
        end
        check("accept_in_time", 128'(n < 20), 128'd1);
        tick();
        in_valid[k] = 1'b0;
        in_inv[k]   = ~inv;
        in_data[k]  = ~d;
    endtask

    task automatic wait_out(input int k, output int cyc);
        cyc = 0;
        while (!out_valid[k] && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic drain(input int k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic check_reset_vals(input int k);
        check("rst_out_valid", 128'(out_valid[k]), 128'd0);
        check("rst_in_ready",  128'(in_ready[k]),  128'd1);
        check("rst_busy",      128'(busy[k]),      128'd0);
        check("rst_out_data",  out_data[k],        128'd0);
`ifdef MIXCOL_PARITY_EN
        check("rst_out_parity", 128'(out_parity[k]), 128'd0);
`endif
    endtask

    localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] V_INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] V_ONES    = 128'h01010101_01010101_01010101_01010101;
    localparam logic [127:0] V_FLUSH   = 128'hc6c6c6c6_00000000_00000000_00000000;
    localparam logic [127:0] V_FLUSHED = 128'hc6c6c6c6_9fdc589d_01010101_c6c6c6c6;

    initial begin
        int cyc;
        logic [127:0] d;
        logic [127:0] f;

        for (int k = 0; k < 3; k++) begin
            flush[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            in_inv[k]    = 1'b0;
            out_ready[k] = 1'b0;
        end

        // Clock/reset
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) check_reset_vals(k);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Forward, C=1
        send(0, V_FWD_IN, 1'b0);
        wait_out(0, cyc);
        check("fwd_c1_latency", 128'(cyc), 128'd4);
        check("fwd_c1_data", out_data[0], V_FWD_OUT);
        check("fwd_c1_busy", 128'(busy[0]), 128'd1);
        check("fwd_c1_in_ready", 128'(in_ready[0]), 128'd0);
`ifdef MIXCOL_PARITY_EN
        check("fwd_c1_parity", 128'(out_parity[0]), 128'(exp_parity(V_FWD_OUT)));
`endif
        drain(0);
        check("fwd_c1_post_valid", 128'(out_valid[0]), 128'd0);
        check("fwd_c1_post_ready", 128'(in_ready[0]), 128'd1);
        check("fwd_c1_post_busy", 128'(busy[0]), 128'd0);

        // Inverse, C=4
        send(2, V_INV_IN, 1'b1);
        wait_out(2, cyc);
        check("inv_c4_latency", 128'(cyc), 128'd1);
        check("inv_c4_data", out_data[2], V_INV_OUT);

        // Backpressure on the C=4 engine sitting in DONE
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 128'(out_valid[2]), 128'd1);
            check("bp_out_data", out_data[2], V_INV_OUT);
            check("bp_in_ready", 128'(in_ready[2]), 128'd0);
        end
        drain(2);
        check("bp_post_valid", 128'(out_valid[2]), 128'd0);
        check("bp_post_ready", 128'(in_ready[2]), 128'd1);
        check("bp_idle_hold", out_data[2], V_INV_OUT);

        // Flush beats a simultaneous accept
        flush[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = V_FWD_IN;
        tick();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        check("flush_vs_accept_ready", 128'(in_ready[0]), 128'd1);
        check("flush_vs_accept_busy", 128'(busy[0]), 128'd0);

        // Flush in the 2nd BUSY cycle (C=1): column 0 is already written
        send(0, V_FLUSH, 1'b0);
        tick();
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        check("flush_in_ready", 128'(in_ready[0]), 128'd1);
        check("flush_busy", 128'(busy[0]), 128'd0);
        check("flush_out_data_held", out_data[0], V_FLUSHED);
        for (int i = 0; i < 6; i++) begin
            check("flush_no_valid", 128'(out_valid[0]), 128'd0);
            tick();
        end
        send(0, V_ONES, 1'b0);
        wait_out(0, cyc);
        check("after_flush_latency", 128'(cyc), 128'd4);
        check("after_flush_data", out_data[0], V_ONES);
        drain(0);

        // Asynchronous reset in the middle of a C=2 block
        send(1, V_FWD_IN, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        check_reset_vals(1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1, V_FWD_IN, 1'b0);
        wait_out(1, cyc);
        check("post_rst_latency", 128'(cyc), 128'd2);
        check("post_rst_data", out_data[1], V_FWD_OUT);
        drain(1);

        // Random round trips on every engine
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 1000; n++) begin
                d = {$urandom_range(32'hffffffff, 0), $urandom_range(32'hffffffff, 0),
                     $urandom_range(32'hffffffff, 0), $urandom_range(32'hffffffff, 0)};
                f = model(d, 1'b0);
                send(k, d, 1'b0);
                wait_out(k, cyc);
                check("rt_fwd_latency", 128'(cyc), 128'(4 / ((k == 0) ? 1 : ((k == 1) ? 2 : 4))));
                check("rt_fwd_data", out_data[k], f);
`ifdef MIXCOL_PARITY_EN
                check("rt_fwd_parity", 128'(out_parity[k]), 128'(exp_parity(f)));
`endif
                drain(k);
                send(k, f, 1'b1);
                wait_out(k, cyc);
                check("rt_inv_data", out_data[k], d);
`ifdef MIXCOL_PARITY_EN
                check("rt_inv_parity", 128'(out_parity[k]), 128'(exp_parity(d)));
`endif
                drain(k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
